// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction stream receiver.
package instr_pkg;

  localparam int unsigned INSTR_WORD_W   = 128;
  localparam int unsigned INSTR_WORDS    = 4;
  localparam int unsigned INSTR_LAST_BIT = 120;

  localparam logic [2:0] TAG_W0 = 3'b100;
  localparam logic [2:0] TAG_W1 = 3'b101;
  localparam logic [2:0] TAG_W2 = 3'b110;
  localparam logic [2:0] TAG_W3 = 3'b111;

  typedef logic [INSTR_WORD_W-1:0] instr_word_t;
  typedef instr_word_t [INSTR_WORDS-1:0] instr_bundle_t;

  typedef enum logic {StIdle, StCollect} rx_state_e;

  function automatic logic [2:0] word_tag(input instr_word_t w);
    return w[INSTR_WORD_W-1 -: 3];
  endfunction

  // Word k of a bundle carries {1'b1, k}.
  function automatic logic [2:0] expected_tag(input logic [1:0] idx);
    return {1'b1, idx};
  endfunction

endpackage

// File: rtl/instr_bundle_fifo.sv
// Register FIFO of assembled instruction bundles; head entry is read straight from storage.
module instr_bundle_fifo
  import instr_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  instr_bundle_t push_data_i,
  input  logic          pop_i,
  output instr_bundle_t head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  instr_bundle_t   mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/instr_axis_rx.sv
// Instruction stream receiver: validates word tags, packs 4-word bundles and queues them
// for the layer controller.
module instr_axis_rx
  import instr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned WORDS_PER_INSTR = 4,
  parameter int unsigned BUF_DEPTH       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_instr_tvalid,
  output logic                                  s_axis_instr_tready,
  input  logic [DATA_WIDTH-1:0]                 s_axis_instr_tdata,
  output logic                                  instr_valid,
  input  logic                                  instr_ready,
  output logic [DATA_WIDTH*WORDS_PER_INSTR-1:0] instr_data,
  output logic                                  instr_last,
  output logic [31:0]                           instr_cnt,
  output logic                                  err_seq,
  input  logic                                  err_clr
);

  rx_state_e         state_q;
  logic [1:0]        idx_q;
  instr_word_t [2:0] part_q;
  logic              rst_q;
  logic              err_seq_q;
  logic [31:0]       instr_cnt_q;

  instr_word_t   word;
  logic [2:0]    tag;
  logic          word_fire, tag_ok, seq_err, push, pop;
  logic          buf_full, buf_empty;
  instr_bundle_t push_bundle, head;

  // No same-cycle pop credit: tready only looks at the registered full flag.
  assign s_axis_instr_tready = !rst_q && !buf_full;

  assign word      = s_axis_instr_tdata;
  assign tag       = word_tag(word);
  assign word_fire = s_axis_instr_tvalid && s_axis_instr_tready;
  // idx_q is 0 in StIdle, so one compare covers both states.
  assign tag_ok    = (tag == expected_tag(idx_q));
  assign seq_err   = word_fire && !tag_ok;
  assign push      = word_fire && (state_q == StCollect) && tag_ok && (tag == TAG_W3);
  assign pop       = instr_valid && instr_ready;

  assign push_bundle = {word, part_q[2], part_q[1], part_q[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      part_q      <= '0;
      rst_q       <= 1'b1;
      err_seq_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      rst_q <= 1'b0;
      if (word_fire) begin
        unique case (state_q)
          StIdle: begin
            if (tag_ok) begin
              part_q[0] <= word;
              idx_q     <= 2'd1;
              state_q   <= StCollect;
            end
          end
          StCollect: begin
            if (tag_ok) begin
              if (idx_q == 2'd3) begin
                idx_q   <= 2'd0;
                state_q <= StIdle;
              end else begin
                part_q[idx_q] <= word;
                idx_q         <= idx_q + 2'd1;
              end
            end else if (tag == TAG_W0) begin
              // A fresh word0 restarts the bundle instead of waiting in idle.
              part_q[0] <= word;
              idx_q     <= 2'd1;
            end else begin
              idx_q   <= 2'd0;
              state_q <= StIdle;
            end
          end
          default: begin
            idx_q   <= 2'd0;
            state_q <= StIdle;
          end
        endcase
      end
      if (seq_err) begin
        err_seq_q <= 1'b1;
      end else if (err_clr) begin
        err_seq_q <= 1'b0;
      end
      if (pop) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  instr_bundle_fifo #(
    .Depth (BUF_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_bundle),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign instr_valid = !buf_empty;
  assign instr_data  = head;
  assign instr_last  = head[0][INSTR_LAST_BIT];
  assign instr_cnt   = instr_cnt_q;
  assign err_seq     = err_seq_q;

endmodule
